// File: rtl/draw_button_pkg.sv
// Shared game parameters for the button drawer: VGA bus widths, colours,
// flash FSM states and the timing bus layout.
package draw_button_pkg;

  localparam int unsigned CountW         = 11;
  localparam int unsigned RgbW           = 12;
  localparam int unsigned DefFlashFrames = 8;

  localparam logic [RgbW-1:0] ColorBlank  = 12'h000;
  localparam logic [RgbW-1:0] ColorInvert = 12'hFFF;

  typedef enum logic [0:0] {
    StIdle,
    StFlash
  } flash_state_e;

  // Timing and count signals travelling through the delay line together.
  typedef struct packed {
    logic [CountW-1:0] hcount;
    logic [CountW-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
  } vga_timing_t;

  localparam int unsigned TimingW = $bits(vga_timing_t);

  // Half-open range test in 12-bit arithmetic so the upper bound cannot wrap.
  function automatic logic in_range(input logic [11:0] val, input logic [11:0] lo,
                                    input logic [11:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/draw_button_if.sv
// VGA pixel bus: counters, sync/blank timing and the pixel colour.
interface draw_button_if;
  import draw_button_pkg::*;

  logic [CountW-1:0] hcount;
  logic [CountW-1:0] vcount;
  logic              hsync;
  logic              vsync;
  logic              hblnk;
  logic              vblnk;
  logic [RgbW-1:0]   rgb;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

endinterface

// File: rtl/draw_button_signal_delay.sv
// Generic register delay line: dout is din delayed by CLK_DEL clock cycles.
module signal_delay #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [CLK_DEL];

  // Shift the bus one stage per clock; reset clears every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CLK_DEL); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(CLK_DEL); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[CLK_DEL-1];

endmodule

// File: rtl/draw_button.sv
// Draws a ROM-backed button image over the VGA stream with a two-stage
// pipeline, and inverts the image for a number of frames after a press.
module draw_button
  import draw_button_pkg::*;
#(
  parameter int          XPOS            = 0,
  parameter int          YPOS            = 0,
  parameter int unsigned ROM_WIDTH_SIZE  = 8,
  parameter int unsigned ROM_HEIGHT_SIZE = 8,
  parameter int unsigned FLASH_FRAMES    = DefFlashFrames
) (
  input  logic                                     pclk,
  input  logic                                     rst_n,
  draw_button_if.slave                             vga_in,
  draw_button_if.master                            vga_out,
  input  logic                                     enable,
  input  logic                                     press,
  output logic [ROM_WIDTH_SIZE+ROM_HEIGHT_SIZE-1:0] rom_address,
  input  logic [RgbW-1:0]                          rom_rgb,
  output logic                                     flashing
);

  localparam int unsigned AddrW = ROM_WIDTH_SIZE + ROM_HEIGHT_SIZE;
  // Keep the counter at least one bit wide when the highlight is disabled.
  localparam int unsigned CntW  = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
  localparam bit          FlashEn = (FLASH_FRAMES != 0);

  localparam logic [11:0] XMin = 12'(XPOS);
  localparam logic [11:0] XMax = 12'(XPOS + (2 ** ROM_WIDTH_SIZE));
  localparam logic [11:0] YMin = 12'(YPOS);
  localparam logic [11:0] YMax = 12'(YPOS + (2 ** ROM_HEIGHT_SIZE));

  localparam logic [CntW-1:0] FramesLoad = CntW'(FLASH_FRAMES);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  // Stage 1 combinational terms.
  logic [11:0]                h_ext, v_ext;
  logic [ROM_WIDTH_SIZE-1:0]  h_off;
  logic [ROM_HEIGHT_SIZE-1:0] v_off;
  logic                       in_area;

  assign h_ext   = {1'b0, vga_in.hcount};
  assign v_ext   = {1'b0, vga_in.vcount};
  assign h_off   = ROM_WIDTH_SIZE'(h_ext - XMin);
  assign v_off   = ROM_HEIGHT_SIZE'(v_ext - YMin);
  assign in_area = in_range(h_ext, XMin, XMax) && in_range(v_ext, YMin, YMax);

  // Stage 1 registers.
  logic [AddrW-1:0] rom_addr_q;
  logic             draw_q;
  logic             blank_q;
  logic [RgbW-1:0]  rgb_q;

  // Stage 2 register and flash FSM state.
  logic [RgbW-1:0]  rgb_out_q;
  flash_state_e     state_q;
  logic [CntW-1:0]  frame_cnt_q;
  logic             vblnk_prev_q;
  logic             flashing_q;

  logic             press_ok;
  logic             vblnk_rise;
  logic [RgbW-1:0]  pix;

  assign press_ok   = press && enable && FlashEn;
  assign vblnk_rise = vga_in.vblnk && !vblnk_prev_q;

  // Stage 1: register area hit, ROM address, blanking and upstream pixel.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      draw_q     <= 1'b0;
      blank_q    <= 1'b0;
      rgb_q      <= '0;
    end else begin
      rom_addr_q <= {v_off, h_off};
      draw_q     <= in_area && enable;
      blank_q    <= vga_in.hblnk || vga_in.vblnk;
      rgb_q      <= vga_in.rgb;
    end
  end

  // Image pixel, inverted while the highlight is active.
  always_comb begin
    pix = rom_rgb;
    if (flashing_q) begin
      pix = rom_rgb ^ ColorInvert;
    end
  end

  // Stage 2: compose the output pixel from blanking, button and background.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out_q <= '0;
    end else if (blank_q) begin
      rgb_out_q <= ColorBlank;
    end else if (draw_q) begin
      rgb_out_q <= pix;
    end else begin
      rgb_out_q <= rgb_q;
    end
  end

  // Flash FSM: a press (re)loads the frame count; each vblnk rising edge counts
  // one frame down. A press in the same cycle as an edge wins.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      frame_cnt_q  <= '0;
      vblnk_prev_q <= 1'b0;
      flashing_q   <= 1'b0;
    end else begin
      vblnk_prev_q <= vga_in.vblnk;
      unique case (state_q)
        StIdle: begin
          if (press_ok) begin
            state_q     <= StFlash;
            frame_cnt_q <= FramesLoad;
            flashing_q  <= 1'b1;
          end
        end
        StFlash: begin
          if (press_ok) begin
            frame_cnt_q <= FramesLoad;
          end else if (vblnk_rise) begin
            if (frame_cnt_q == CntOne) begin
              state_q     <= StIdle;
              frame_cnt_q <= '0;
              flashing_q  <= 1'b0;
            end else begin
              frame_cnt_q <= frame_cnt_q - CntOne;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          frame_cnt_q <= '0;
          flashing_q  <= 1'b0;
        end
      endcase
    end
  end

  // Timing and counters ride a two-cycle delay line to stay aligned with rgb.
  vga_timing_t timing_in, timing_out;

  assign timing_in = '{
    hcount: vga_in.hcount,
    vcount: vga_in.vcount,
    hsync:  vga_in.hsync,
    vsync:  vga_in.vsync,
    hblnk:  vga_in.hblnk,
    vblnk:  vga_in.vblnk
  };

  signal_delay #(
    .WIDTH   (TimingW),
    .CLK_DEL (2)
  ) u_timing_delay (
    .clk   (pclk),
    .rst_n (rst_n),
    .din   (timing_in),
    .dout  (timing_out)
  );

  assign vga_out.hcount = timing_out.hcount;
  assign vga_out.vcount = timing_out.vcount;
  assign vga_out.hsync  = timing_out.hsync;
  assign vga_out.vsync  = timing_out.vsync;
  assign vga_out.hblnk  = timing_out.hblnk;
  assign vga_out.vblnk  = timing_out.vblnk;
  assign vga_out.rgb    = rgb_out_q;

  assign rom_address = rom_addr_q;
  assign flashing    = flashing_q;

endmodule

// File: tb/tb_draw_button.sv
// Bench for draw_button: randomized and directed pixels, frame-count flash
// reference model, and a queue-based scoreboard checked by a monitor.
module tb_draw_button;
  import draw_button_pkg::*;

  localparam int XP = 100;
  localparam int YP = 50;
  localparam int WS = 8;
  localparam int HS = 8;
  localparam int FF = 3;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        press = 1'b0;
  logic [15:0] rom_address;
  logic [11:0] rom_rgb;
  logic        flashing;

  draw_button_if vin ();
  draw_button_if vout ();

  // ROM model: pixel colour is the low 12 bits of its address.
  assign rom_rgb = rom_address[11:0];

  always #5 pclk = ~pclk;

  draw_button #(
    .XPOS            (XP),
    .YPOS            (YP),
    .ROM_WIDTH_SIZE  (WS),
    .ROM_HEIGHT_SIZE (HS),
    .FLASH_FRAMES    (FF)
  ) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .vga_in      (vin),
    .vga_out     (vout),
    .enable      (enable),
    .press       (press),
    .rom_address (rom_address),
    .rom_rgb     (rom_rgb),
    .flashing    (flashing)
  );

  typedef struct {
    logic [25:0] timing;
    logic [11:0] rgb;
    logic        fl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   remaining = 0;
  logic prev_vb = 1'b0;
  logic vb_state = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // One input cycle: apply inputs, advance the reference model, queue expectation.
  task automatic drive(input int h, input int v, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic [11:0] rgb,
                       input logic en, input logic pr);
    exp_t e;
    int hrel, vrel;
    logic [11:0] pixel;
    bit in_btn;
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rgb;
    enable     = en;
    press      = pr;
    if (pr && en) remaining = FF;
    else if (vb && !prev_vb && remaining > 0) remaining--;
    prev_vb = vb;
    hrel   = h - XP;
    vrel   = v - YP;
    in_btn = (hrel >= 0) && (hrel < 2 ** WS) && (vrel >= 0) && (vrel < 2 ** HS);
    pixel  = 12'((vrel * 256 + hrel) % 4096);
    if (remaining > 0) pixel = ~pixel;
    e.timing = {11'(h), 11'(v), hs, vs, hb, vb};
    e.rgb    = (hb || vb) ? 12'h000 : (in_btn && en) ? pixel : rgb;
    e.fl     = (remaining > 0);
    q.push_back(e);
    @(negedge pclk);
  endtask

  task automatic px(input int h, input int v, input logic vb, input logic pr);
    drive(h, v, 1'b0, 1'b0, 1'b0, vb, 12'(h * 7 + v), 1'b1, pr);
  endtask

  task automatic zero_inputs();
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 0; vin.vsync = 0;
    vin.hblnk = 0; vin.vblnk = 0; vin.rgb = '0; enable = 0; press = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rgb"}, 32'(vout.rgb), 32'd0);
    chk({tag, "_timing"}, 32'({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                               vout.hblnk, vout.vblnk}), 32'd0);
    chk({tag, "_flashing"}, 32'(flashing), 32'd0);
    chk({tag, "_rom_address"}, 32'(rom_address), 32'd0);
  endtask

  // Asserted off-edge to exercise the asynchronous clear; released on a negedge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    q.delete();
    remaining = 0;
    prev_vb   = 1'b0;
    #1 check_zero(tag);
    zero_inputs();
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
  endtask

  // Monitor: flashing tracks the latest cycle; pixel outputs lag by two.
  always @(posedge pclk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (q.size() >= 1) chk("flashing", 32'(flashing), 32'(q[q.size()-1].fl));
      if (q.size() >= 2) begin
        e = q.pop_front();
        chk("rgb_out", 32'(vout.rgb), 32'(e.rgb));
        chk("timing_out", 32'({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                              vout.hblnk, vout.vblnk}), 32'(e.timing));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    zero_inputs();
    @(negedge pclk);
    do_reset("reset_init");

    // Top-left pixel of the button, then right-edge boundaries and blanking.
    px(100, 50, 1'b0, 1'b0);
    drive(99, 60, 0, 0, 0, 0, 12'hABC, 1, 0);
    drive(355, 60, 0, 0, 0, 0, 12'hABC, 1, 0);
    drive(356, 60, 0, 0, 0, 0, 12'hABC, 1, 0);
    drive(150, 60, 0, 0, 1, 0, 12'h123, 1, 0);
    drive(150, 49, 0, 0, 0, 0, 12'h456, 1, 0);
    drive(150, 306, 0, 0, 0, 0, 12'h789, 1, 0);
    drive(150, 305, 1, 1, 0, 0, 12'h789, 1, 0);
    drive(150, 60, 0, 0, 0, 0, 12'h5A5, 0, 0);
    drive(200, 100, 0, 0, 0, 0, 12'h111, 0, 1);

    // Flash: press, then three vblnk rising edges with F00 pixels in between.
    px(100, 65, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      px(100, 65, 1'b0, 1'b0);
      px(101, 65, 1'b0, 1'b0);
      px(100, 65, 1'b1, 1'b0);
      px(100, 65, 1'b1, 1'b0);
    end
    px(100, 65, 1'b0, 1'b0);
    px(100, 65, 1'b0, 1'b0);

    // Press coinciding with the final vblnk edge reloads instead of expiring.
    px(120, 70, 1'b0, 1'b1);
    px(120, 70, 1'b1, 1'b0);
    px(120, 70, 1'b0, 1'b0);
    px(120, 70, 1'b1, 1'b0);
    px(120, 70, 1'b0, 1'b0);
    px(120, 70, 1'b1, 1'b1);
    px(120, 70, 1'b0, 1'b0);
    px(120, 70, 1'b1, 1'b0);
    px(120, 70, 1'b0, 1'b0);

    // Randomized traffic around the button with occasional presses and frames.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) vb_state = ~vb_state;
      drive($urandom_range(60, 400), $urandom_range(20, 330), 1'($urandom),
            1'($urandom), ($urandom_range(0, 9) == 0), vb_state, 12'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
    end

    // Reset mid-flash and mid-line, then normal drawing resumes.
    vb_state = 1'b0;
    px(130, 80, 1'b0, 1'b1);
    px(131, 80, 1'b0, 1'b0);
    px(132, 80, 1'b0, 1'b0);
    do_reset("reset_midflash");
    for (int i = 0; i < 20; i++) begin
      px(90 + i * 15, 55 + i * 3, 1'b0, 1'b0);
    end
    px(0, 0, 1'b0, 1'b0);
    px(0, 0, 1'b0, 1'b0);
    @(negedge pclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_button.md
DRAW_BUTTON -- requirements
Module: draw_button

Interface
REQ-001 Parameter XPOS, default 0: button left edge, pixels.
REQ-002 Parameter YPOS, default 0: button top edge, pixels.
REQ-003 Parameter ROM_WIDTH_SIZE, default 8: log2 of the image width; the ROM x-address width.
REQ-004 Parameter ROM_HEIGHT_SIZE, default 8: log2 of the image height; the ROM y-address width.
REQ-005 Parameter FLASH_FRAMES, default 8: frames of press highlight.
REQ-006 pclk  in  1: pixel clock. The block SHALL use this single clock.
REQ-007 rst_n  in  1: reset, asynchronous, active-low.
REQ-008 hcount_in, vcount_in  in  11 each: VGA counters.
REQ-009 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each: VGA timing.
REQ-010 rgb_in  in  12: upstream pixel.
REQ-011 enable  in  1: draw the button when 1.
REQ-012 press  in  1: one-cycle press pulse.
REQ-013 rom_address  out  ROM_WIDTH_SIZE+ROM_HEIGHT_SIZE: address {y, x} to the button image ROM.
REQ-014 rom_rgb  in  12: combinational ROM pixel for rom_address.
REQ-015 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out: inputs delayed 2 cycles.
REQ-016 rgb_out  out  12: composed pixel.
REQ-017 flashing  out  1: high while the highlight is active.

Function
REQ-018 Stage 1 SHALL register in_area = (XPOS <= hcount_in < XPOS+2**ROM_WIDTH_SIZE) and (YPOS <= vcount_in < YPOS+2**ROM_HEIGHT_SIZE), computed in 12-bit arithmetic with no wrap.
REQ-019 Stage 1 SHALL register rom_address = {(vcount_in-YPOS)[ROM_HEIGHT_SIZE-1:0], (hcount_in-XPOS)[ROM_WIDTH_SIZE-1:0]}.
REQ-020 Stage 1 SHALL register the timing signals and rgb_in.
REQ-021 Stage 2 SHALL sample rom_rgb in the cycle after the address is registered.
REQ-022 Stage 2 SHALL set rgb_out to 12'h000 when hblnk or vblnk is high.
REQ-023 Otherwise, stage 2 SHALL set rgb_out to the pixel pix when in_area and enable are both high.
REQ-024 Otherwise, stage 2 SHALL set rgb_out to the delayed rgb_in.
REQ-025 pix SHALL be ~rom_rgb when flashing is 1, and rom_rgb otherwise.
REQ-026 Total latency from the inputs to every output SHALL be exactly 2 pclk cycles, with all outputs mutually aligned.
REQ-027 The flash FSM SHALL have two states: IDLE and FLASH.
REQ-028 From IDLE, a press pulse SHALL move the FSM to FLASH and load frame_cnt = FLASH_FRAMES.
REQ-029 In FLASH, each rising edge of vblnk_in SHALL decrement frame_cnt.
REQ-030 In FLASH, when frame_cnt is 1 and a vblnk_in rising edge occurs, the FSM SHALL return to IDLE.
REQ-031 A press pulse in FLASH SHALL reload frame_cnt = FLASH_FRAMES and stay in FLASH.
REQ-032 A press pulse and a vblnk rising edge in the same cycle SHALL reload the counter; the reload wins.
REQ-033 A press pulse while enable is 0 SHALL be ignored.
REQ-034 flashing SHALL be the registered value (state == FLASH).
REQ-035 frame_cnt SHALL be $clog2(FLASH_FRAMES+1) bits wide.
REQ-036 FLASH_FRAMES = 0 SHALL disable the highlight: press is ignored.

Reset
REQ-037 When rst_n is low, all pipeline registers, rom_address and the outputs SHALL be 0.
REQ-038 When rst_n is low, the FSM SHALL be IDLE, frame_cnt SHALL be 0, and the vblnk edge detector register SHALL be 0.
REQ-039 A reset asserted mid-frame or mid-flash SHALL abort immediately.
REQ-040 After reset release, valid output SHALL appear 2 cycles after the first valid input.

Structure
REQ-041 Button colours, VGA widths (11-bit counter, 12-bit RGB) and the default FLASH_FRAMES SHALL reside in the shared _game_params.vh.
REQ-042 The ROM SHALL stay external, so that several buttons can share one drawer.
REQ-043 The timing delay SHALL be a reusable sub-module, signal_delay (parameters WIDTH, CLK_DEL), instantiated for the timing and count bus.

Verification
REQ-044 XPOS=100, YPOS=50, sizes 8/8, pixel (hcount=100, vcount=50) with rom_rgb model = address[11:0] -> rom_address=16'h0000; 2 cycles later rgb_out = model value.
REQ-045 Boundary: hcount = 99, 355 and 356 at vcount = 60 -> 99 and 356 pass rgb_in through; 355 draws ROM pixel x=255.
REQ-046 Blanking: hblnk_in=1 inside the button area -> rgb_out = 12'h000.
REQ-047 Flash: press pulse, then 3 vblnk rising edges with FLASH_FRAMES=3 -> flashing high; button pixels inverted (rom_rgb 12'hF00 -> 12'h0FF); flashing drops after the 3rd edge.
REQ-048 Simultaneous press and vblnk edge while frame_cnt=1 -> stays in FLASH, frame_cnt = FLASH_FRAMES.
REQ-049 rst_n pulled low mid-flash and mid-line -> all outputs 0 and flashing 0 asynchronously; normal drawing after release with 2-cycle latency.
